// File: rtl/mips_chk_pkg.sv
// -----------------------------------------------------------------------------
// mips_chk_pkg
// Shared types and constants for the MIPS data-memory write checker.
//   chk_state_t : checker FSM state encoding
//   FC_*        : fail_code values reported on the fail_code output
//   sat_inc8    : saturating 8-bit increment used by the RUN cycle counter
// -----------------------------------------------------------------------------
package mips_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chk_state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_BADCNT   = 2'd3;

    // Counter sticks at 255 instead of wrapping back to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mips_write_checker_chk_table.sv
// -----------------------------------------------------------------------------
// chk_table
// Expected-write table: DEPTH entries of {address, data}, one synchronous
// write port and one asynchronous read port.
// Ports:
//   clk    in  clock (write on posedge)
//   we     in  write enable
//   widx   in  write index
//   wadr   in  expected address to store
//   wdata  in  expected data to store
//   ridx   in  read index (checker pointer)
//   radr   out stored address at ridx
//   rdata  out stored data at ridx
// The storage is intentionally not reset; the checker's entry count gates use.
// -----------------------------------------------------------------------------
module chk_table #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] ridx,
    output logic [AW-1:0] radr,
    output logic [DW-1:0] rdata
);

    logic [AW-1:0] adr_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    // Out-of-range indices (non power-of-two DEPTH) are dropped.
    always_ff @(posedge clk) begin
        if (we && (int'(widx) < DEPTH)) begin
            adr_mem[widx]  <= wadr;
            data_mem[widx] <= wdata;
        end
    end

    assign radr  = adr_mem[ridx];
    assign rdata = data_mem[ridx];

endmodule

// File: rtl/mips_write_checker.sv
// -----------------------------------------------------------------------------
// mips_write_checker
// Snoops the MIPS data-memory write bus and compares each write against an
// ordered table of expected (address, data) pairs. Writes that fall inside
// the scratch window [IGN_LO, IGN_HI] are ignored. Reports pass, fail with a
// reason code, or timeout after LIMIT RUN cycles.
// Ports:
//   clk        in  clock
//   reset      in  asynchronous active-low reset
//   prog_we    in  write table entry prog_idx (IDLE only)
//   prog_idx   in  table index
//   prog_adr   in  expected address
//   prog_data  in  expected data
//   prog_count in  number of valid entries, latched on start
//   start      in  IDLE -> RUN
//   memwrite   in  snooped write strobe
//   dataadr    in  snooped address
//   writedata  in  snooped data
//   busy       out checker in RUN
//   done       out checker finished (pass or fail), sticky until reset
//   pass       out checker finished with pass
//   fail_code  out failure reason (see mips_chk_pkg FC_*)
//   fail_idx   out table index being checked when the failure occurred
//   fail_data  out writedata captured on mismatch (0 on timeout)
//   cycle_cnt  out RUN cycles elapsed, saturating at 255
// -----------------------------------------------------------------------------
module mips_write_checker
    import mips_chk_pkg::*;
#(
    parameter  int AW     = 32,
    parameter  int DW     = 32,
    parameter  int DEPTH  = 8,
    parameter  int LIMIT  = 20,
    parameter  int IGN_LO = 80,
    parameter  int IGN_HI = 80,
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [IW-1:0] prog_idx,
    input  logic [AW-1:0] prog_adr,
    input  logic [DW-1:0] prog_data,
    input  logic [CW-1:0] prog_count,
    input  logic          start,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [1:0]    fail_code,
    output logic [IW-1:0] fail_idx,
    output logic [DW-1:0] fail_data,
    output logic [7:0]    cycle_cnt
);

    localparam logic [AW-1:0] IGN_LO_A = AW'(IGN_LO);
    localparam logic [AW-1:0] IGN_HI_A = AW'(IGN_HI);
    localparam bit            WIN_EN   = (IGN_LO <= IGN_HI);
    // A budget of 255 or more can never be exceeded by the saturating counter.
    localparam int            LIMIT_C  = (LIMIT > 255) ? 255 : LIMIT;
    localparam logic [7:0]    LIMIT_8  = 8'(LIMIT_C);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    chk_state_t    state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] count;

    logic [AW-1:0] exp_adr;
    logic [DW-1:0] exp_data;

    logic          in_window;
    logic          wr_seen;
    logic          wr_match;
    logic          last_entry;
    logic [7:0]    cnt_next;
    logic          timeout;

    // Table writes are only accepted while idle, so a running check cannot
    // have its expectations changed underneath it.
    chk_table #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_table (
        .clk   (clk),
        .we    (prog_we && (state == IDLE)),
        .widx  (prog_idx),
        .wadr  (prog_adr),
        .wdata (prog_data),
        .ridx  (ptr),
        .radr  (exp_adr),
        .rdata (exp_data)
    );

    assign in_window  = WIN_EN && (dataadr >= IGN_LO_A) && (dataadr <= IGN_HI_A);
    assign wr_seen    = memwrite && !in_window;
    assign wr_match   = (dataadr == exp_adr) && (writedata == exp_data);
    assign last_entry = (CW'(ptr) == (count - CW'(1)));
    // Timeout is judged on the count this edge will produce, so the failure
    // is reported with cycle_cnt = LIMIT+1.
    assign cnt_next   = sat_inc8(cycle_cnt);
    assign timeout    = (cnt_next > LIMIT_8);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            count     <= '0;
            cycle_cnt <= '0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
            fail_data <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (prog_count > DEPTH_C) begin
                            state     <= FAIL;
                            fail_code <= FC_BADCNT;
                            fail_idx  <= '0;
                            done      <= 1'b1;
                        end else if (prog_count == '0) begin
                            state <= PASS;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            count     <= prog_count;
                            ptr       <= '0;
                            cycle_cnt <= '0;
                            busy      <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    cycle_cnt <= cnt_next;
                    // A mismatch outranks timeout; a final match outranks it too.
                    if (wr_seen && !wr_match) begin
                        state     <= FAIL;
                        fail_code <= FC_MISMATCH;
                        fail_idx  <= ptr;
                        fail_data <= writedata;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (wr_seen && last_entry) begin
                        state <= PASS;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (timeout) begin
                        state     <= FAIL;
                        fail_code <= FC_TIMEOUT;
                        fail_idx  <= wr_seen ? ptr + IW'(1) : ptr;
                        fail_data <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (wr_seen) begin
                        ptr <= ptr + IW'(1);
                    end
                end

                // PASS and FAIL hold until reset.
                default: begin
                end
            endcase
        end
    end

endmodule
